pc_unit: RTL and testbench

Parametrised program-counter unit for the pipelined MIPS core's IF stage; successor to the single-register PC. Holds the fetch address and selects the next one from sequential, branch/jump redirect, exception vector and ERET return. A one-entry pending-redirect buffer keeps a redirect that arrives during a stall and applies it when the stall releases. Flags fetch-address errors for the CP0 exception logic.

---
 rtl/pc_pkg.sv | 18 +
 rtl/pc_unit_if.sv | 25 ++
 rtl/pc_redirect_buf.sv | 31 +++
 rtl/pc_unit.sv | 84 ++++++++
 tb/tb_pc_unit.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared defaults and next-PC source encoding for the IF-stage program counter.
package pc_pkg;

  localparam logic [31:0] RESET_VEC_DEF  = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF    = 32'h0000_4180;
  localparam logic [31:0] IMEM_BASE_DEF  = 32'h0000_3000;
  localparam int unsigned IMEM_BYTES_DEF = 16384;

  typedef enum logic [2:0] {
    NPC_EXC,
    NPC_ERET,
    NPC_BR,
    NPC_PEND,
    NPC_SEQ,
    NPC_HOLD
  } npc_src_e;

endpackage

// File: rtl/pc_unit_if.sv
// Control/redirect inputs and fetch-address outputs of the program-counter unit.
interface pc_unit_if #(
  parameter int WIDTH = 32
);
  logic             En;
  logic             Br;
  logic [WIDTH-1:0] BrTarget;
  logic             Exc;
  logic             Eret;
  logic [WIDTH-1:0] Epc;
  logic [WIDTH-1:0] Out;
  logic [WIDTH-1:0] OutPlus4;
  logic             PendValid;
  logic             FetchErr;

  modport master (
    output En, Br, BrTarget, Exc, Eret, Epc,
    input  Out, OutPlus4, PendValid, FetchErr
  );

  modport slave (
    input  En, Br, BrTarget, Exc, Eret, Epc,
    output Out, OutPlus4, PendValid, FetchErr
  );
endinterface

// File: rtl/pc_redirect_buf.sv
// One-entry buffer holding a redirect target that arrived while fetch was stalled.
module pc_redirect_buf #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_target,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_target
);

  logic             r_valid;
  logic [WIDTH-1:0] r_target;

  // Clear wins over load; the target itself is qualified by r_valid so it needs no reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_valid <= 1'b0;
    else if (i_clr)  r_valid <= 1'b0;
    else if (i_load) r_valid <= 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_load) r_target <= i_target;
  end

  assign o_valid  = r_valid;
  assign o_target = r_target;

endmodule

// File: rtl/pc_unit.sv
// IF-stage program counter: prioritised next-PC selection, stall-time redirect
// buffering and fetch-window error flag.
module pc_unit
  import pc_pkg::*;
#(
  parameter int             WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_VEC  = WIDTH'(RESET_VEC_DEF),
  parameter logic [WIDTH-1:0] EXC_VEC    = WIDTH'(EXC_VEC_DEF),
  parameter logic [WIDTH-1:0] IMEM_BASE  = WIDTH'(IMEM_BASE_DEF),
  parameter int unsigned    IMEM_BYTES = IMEM_BYTES_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  pc_unit_if.slave    bus
);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_plus4;
  logic [WIDTH-1:0] w_pend_target;
  logic             w_pend_valid;
  logic             w_buf_load;
  logic             w_buf_clr;
  npc_src_e         w_src;

  logic [WIDTH:0]   w_pc_ext;
  logic [WIDTH:0]   w_lo_ext;
  logic [WIDTH:0]   w_hi_ext;

  assign w_plus4 = r_pc + WIDTH'(4);

  always_comb begin
    w_src = NPC_HOLD;
    if (bus.Exc)            w_src = NPC_EXC;
    else if (bus.Eret)      w_src = NPC_ERET;
    else if (bus.En) begin
      if (bus.Br)           w_src = NPC_BR;
      else if (w_pend_valid) w_src = NPC_PEND;
      else                  w_src = NPC_SEQ;
    end
  end

  always_comb begin
    w_next = r_pc;
    case (w_src)
      NPC_EXC:  w_next = EXC_VEC;
      NPC_ERET: w_next = bus.Epc;
      NPC_BR:   w_next = bus.BrTarget;
      NPC_PEND: w_next = w_pend_target;
      NPC_SEQ:  w_next = w_plus4;
      default:  w_next = r_pc;
    endcase
  end

  // Any taken PC update empties the buffer; only a stalled, un-preempted Br fills it.
  assign w_buf_clr  = bus.Exc | bus.Eret | bus.En;
  assign w_buf_load = ~bus.Exc & ~bus.Eret & ~bus.En & bus.Br;

  pc_redirect_buf #(.WIDTH(WIDTH)) u_buf (
    .i_clk    (Clk),
    .i_rst_n  (Reset),
    .i_load   (w_buf_load),
    .i_clr    (w_buf_clr),
    .i_target (bus.BrTarget),
    .o_valid  (w_pend_valid),
    .o_target (w_pend_target)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_pc <= RESET_VEC;
    else        r_pc <= w_next;
  end

  // Window bound is one bit wider so IMEM_BASE + IMEM_BYTES cannot wrap.
  assign w_pc_ext = {1'b0, r_pc};
  assign w_lo_ext = {1'b0, IMEM_BASE};
  assign w_hi_ext = {1'b0, IMEM_BASE} + (WIDTH+1)'(IMEM_BYTES);

  assign bus.Out       = r_pc;
  assign bus.OutPlus4  = w_plus4;
  assign bus.PendValid = w_pend_valid;
  assign bus.FetchErr  = (|r_pc[1:0]) | (w_pc_ext < w_lo_ext) | (w_pc_ext >= w_hi_ext);

endmodule

// File: tb/tb_pc_unit.sv
// Directed, table-driven bench for pc_unit (32-bit default instance plus a 16-bit wrap instance).
module tb_pc_unit;
  import pc_pkg::*;

  typedef struct {
    logic        en;
    logic        br;
    logic [31:0] brt;
    logic        exc;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] exp_out;
    logic        exp_pv;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rst16_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  pc_unit_if #(.WIDTH(32)) bus ();
  pc_unit_if #(.WIDTH(16)) bus16 ();

  pc_unit dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  pc_unit #(
    .WIDTH      (16),
    .RESET_VEC  (16'hFFF8),
    .EXC_VEC    (16'hFFF0),
    .IMEM_BASE  (16'hFFF0),
    .IMEM_BYTES (32)
  ) dut16 (
    .Clk   (clk),
    .Reset (rst16_n),
    .bus   (bus16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic en, input logic br, input logic [31:0] brt,
                              input logic exc, input logic eret, input logic [31:0] epc,
                              input logic [31:0] exp_out, input logic exp_pv, input logic exp_err);
    vec_t v;
    v.en = en; v.br = br; v.brt = brt; v.exc = exc; v.eret = eret; v.epc = epc;
    v.exp_out = exp_out; v.exp_pv = exp_pv; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.En = 1'b0; bus.Br = 1'b0; bus.BrTarget = '0;
    bus.Exc = 1'b0; bus.Eret = 1'b0; bus.Epc = '0;
  endtask

  task automatic run_table(input vec_t tv[$], input string tag);
    for (int i = 0; i < tv.size(); i++) begin
      bus.En = tv[i].en; bus.Br = tv[i].br; bus.BrTarget = tv[i].brt;
      bus.Exc = tv[i].exc; bus.Eret = tv[i].eret; bus.Epc = tv[i].epc;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("%s[%0d] Out", tag, i), bus.Out, tv[i].exp_out);
      chk($sformatf("%s[%0d] OutPlus4", tag, i), bus.OutPlus4, tv[i].exp_out + 32'd4);
      chk($sformatf("%s[%0d] PendValid", tag, i), {31'd0, bus.PendValid}, {31'd0, tv[i].exp_pv});
      chk($sformatf("%s[%0d] FetchErr", tag, i), {31'd0, bus.FetchErr}, {31'd0, tv[i].exp_err});
    end
  endtask

  vec_t tv1[$];
  vec_t tv2[$];

  initial begin
    // run up, then stall with a redirect so the buffer is full when reset hits
    tv1.push_back(mk(1, 0, 32'h0, 0, 0, 32'h0, 32'h3004, 0, 0));
    tv1.push_back(mk(1, 0, 32'h0, 0, 0, 32'h0, 32'h3008, 0, 0));
    tv1.push_back(mk(1, 0, 32'h0, 0, 0, 32'h0, 32'h300C, 0, 0));
    tv1.push_back(mk(1, 0, 32'h0, 0, 0, 32'h0, 32'h3010, 0, 0));
    tv1.push_back(mk(0, 1, 32'h3500, 0, 0, 32'h0, 32'h3010, 1, 0));

    tv2.push_back(mk(1, 0, 32'h0, 0, 0, 32'h0, 32'h3004, 0, 0));
    tv2.push_back(mk(1, 0, 32'h0, 0, 0, 32'h0, 32'h3008, 0, 0));
    tv2.push_back(mk(1, 0, 32'h0, 0, 0, 32'h0, 32'h300C, 0, 0));
    tv2.push_back(mk(1, 1, 32'h3020, 0, 0, 32'h0, 32'h3020, 0, 0));
    tv2.push_back(mk(0, 1, 32'h3100, 0, 0, 32'h0, 32'h3020, 1, 0));
    tv2.push_back(mk(0, 1, 32'h3100, 0, 0, 32'h0, 32'h3020, 1, 0));
    tv2.push_back(mk(1, 0, 32'h0, 0, 0, 32'h0, 32'h3100, 0, 0));
    tv2.push_back(mk(1, 0, 32'h0, 0, 0, 32'h0, 32'h3104, 0, 0));
    tv2.push_back(mk(0, 1, 32'h3100, 0, 0, 32'h0, 32'h3104, 1, 0));
    tv2.push_back(mk(1, 1, 32'h3200, 0, 0, 32'h0, 32'h3200, 0, 0));
    tv2.push_back(mk(1, 0, 32'h0, 0, 0, 32'h0, 32'h3204, 0, 0));
    tv2.push_back(mk(0, 1, 32'h3300, 0, 0, 32'h0, 32'h3204, 1, 0));
    tv2.push_back(mk(0, 0, 32'h0, 1, 1, 32'h3024, 32'h4180, 0, 0));
    tv2.push_back(mk(0, 0, 32'h0, 0, 1, 32'h3024, 32'h3024, 0, 0));
    tv2.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0, 32'h3024, 0, 0));
    tv2.push_back(mk(0, 0, 32'h0, 1, 0, 32'h0, 32'h4180, 0, 0));
    tv2.push_back(mk(1, 1, 32'h3500, 0, 1, 32'h3040, 32'h3040, 0, 0));
    tv2.push_back(mk(1, 1, 32'h3002, 0, 0, 32'h0, 32'h3002, 0, 1));
    tv2.push_back(mk(1, 0, 32'h0, 0, 0, 32'h0, 32'h3006, 0, 1));
    tv2.push_back(mk(1, 1, 32'h7000, 0, 0, 32'h0, 32'h7000, 0, 1));
    tv2.push_back(mk(1, 1, 32'h6FFC, 0, 0, 32'h0, 32'h6FFC, 0, 0));
    tv2.push_back(mk(1, 0, 32'h0, 0, 0, 32'h0, 32'h7000, 0, 1));
    tv2.push_back(mk(1, 1, 32'h2FFC, 0, 0, 32'h0, 32'h2FFC, 0, 1));
    tv2.push_back(mk(1, 0, 32'h0, 0, 0, 32'h0, 32'h3000, 0, 0));
    tv2.push_back(mk(1, 1, 32'hFFFF_FFFC, 0, 0, 32'h0, 32'hFFFF_FFFC, 0, 1));
    tv2.push_back(mk(1, 0, 32'h0, 0, 0, 32'h0, 32'h0000_0000, 0, 1));
    tv2.push_back(mk(0, 1, 32'h3400, 0, 0, 32'h0, 32'h0000_0000, 1, 1));
    tv2.push_back(mk(0, 1, 32'h3500, 0, 0, 32'h0, 32'h0000_0000, 1, 1));
    tv2.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0, 32'h0000_0000, 1, 1));
    tv2.push_back(mk(1, 0, 32'h0, 0, 0, 32'h0, 32'h3500, 0, 0));

    rst_n = 1'b0;
    rst16_n = 1'b0;
    idle_inputs();
    bus16.En = 1'b0; bus16.Br = 1'b0; bus16.BrTarget = '0;
    bus16.Exc = 1'b0; bus16.Eret = 1'b0; bus16.Epc = '0;

    repeat (2) @(negedge clk);
    chk("reset Out", bus.Out, 32'h3000);
    chk("reset OutPlus4", bus.OutPlus4, 32'h3004);
    chk("reset PendValid", {31'd0, bus.PendValid}, 32'd0);
    chk("reset FetchErr", {31'd0, bus.FetchErr}, 32'd0);
    rst_n = 1'b1;

    run_table(tv1, "pre");

    // asynchronous reset mid-stall with the buffer full
    #2 rst_n = 1'b0;
    #1;
    chk("async rst Out", bus.Out, 32'h3000);
    chk("async rst PendValid", {31'd0, bus.PendValid}, 32'd0);
    idle_inputs();
    @(negedge clk);
    chk("held rst Out", bus.Out, 32'h3000);
    rst_n = 1'b1;

    run_table(tv2, "main");

    // 16-bit instance: sequential wrap through 0 and window tracking
    idle_inputs();
    chk("w16 reset Out", {16'd0, bus16.Out}, 32'h0000_FFF8);
    chk("w16 reset FetchErr", {31'd0, bus16.FetchErr}, 32'd0);
    rst16_n = 1'b1;
    bus16.En = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("w16 edge1 Out", {16'd0, bus16.Out}, 32'h0000_FFFC);
    chk("w16 edge1 OutPlus4", {16'd0, bus16.OutPlus4}, 32'h0000_0000);
    chk("w16 edge1 FetchErr", {31'd0, bus16.FetchErr}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("w16 edge2 Out", {16'd0, bus16.Out}, 32'h0000_0000);
    chk("w16 edge2 FetchErr", {31'd0, bus16.FetchErr}, 32'd1);
    bus16.En = 1'b0;
    bus16.Exc = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("w16 exc Out", {16'd0, bus16.Out}, 32'h0000_FFF0);
    chk("w16 exc FetchErr", {31'd0, bus16.FetchErr}, 32'd0);
    bus16.Exc = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
